// File: rtl/rat_multi.sv
// -----------------------------------------------------------------------------
// rat_multi -- multi-lane register alias table for the rename stage.
//
// Maps up to RENAME_WIDTH instructions' architectural sources to physical
// registers each cycle. Reads resolve, in priority order:
//   1. x0
//   2. intra-group bypass from an older lane
//   3. CDB wakeup forwarding
//   4. the table itself
//
// NUM_CKPT branch checkpoints snoop the CDB every cycle. A restore reloads an
// up-to-date mapping in one cycle.
//
// Optional feature (macro RAT_PERF_CNT_EN): adds perf_restore_cnt and
// perf_ckpt_stall_cnt, both 32-bit wrapping counters.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ren_valid          per-lane instruction valid
//   ars1, ars2, ard    per-lane source / destination architectural registers
//   rd_wen, prd        per-lane destination write enable and new physical reg
//   prs1_rdata,        per-lane {ready, preg}, registered
//   prs2_rdata
//   ren_out_valid      registered ren_valid, forced to 0 after a restore
//   ckpt_alloc,        checkpoint allocate / lowest free slot / all slots busy
//   ckpt_id,
//   ckpt_full
//   ckpt_free,         release a checkpoint slot
//   ckpt_free_id
//   restore,           mispredict recovery and younger-slot kill mask
//   restore_id,
//   restore_kill_mask
//   cdb_valid,         common data bus broadcasts
//   cdb_ard,
//   cdb_prd
// -----------------------------------------------------------------------------
module rat_multi #(
    parameter int NUM_ARCH_REGS  = 32,
    parameter int ARCH_W         = 5,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int RENAME_WIDTH   = 2,
    parameter int NUM_CDB        = 2,
    parameter int NUM_CKPT       = 4,
    localparam int CKPT_W        = $clog2(NUM_CKPT)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [RENAME_WIDTH-1:0]                      ren_valid,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]          ars1,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]          ars2,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]          ard,
    input  logic [RENAME_WIDTH-1:0]                      rd_wen,
    input  logic [RENAME_WIDTH-1:0][PHYS_REG_WIDTH-1:0]  prd,
    output logic [RENAME_WIDTH-1:0][PHYS_REG_WIDTH:0]    prs1_rdata,
    output logic [RENAME_WIDTH-1:0][PHYS_REG_WIDTH:0]    prs2_rdata,
    output logic [RENAME_WIDTH-1:0]                      ren_out_valid,
    input  logic                                         ckpt_alloc,
    output logic [CKPT_W-1:0]                            ckpt_id,
    output logic                                         ckpt_full,
    input  logic                                         ckpt_free,
    input  logic [CKPT_W-1:0]                            ckpt_free_id,
    input  logic                                         restore,
    input  logic [CKPT_W-1:0]                            restore_id,
    input  logic [NUM_CKPT-1:0]                          restore_kill_mask,
    input  logic [NUM_CDB-1:0]                           cdb_valid,
    input  logic [NUM_CDB-1:0][ARCH_W-1:0]               cdb_ard,
    input  logic [NUM_CDB-1:0][PHYS_REG_WIDTH-1:0]       cdb_prd
`ifdef RAT_PERF_CNT_EN
    ,
    output logic [31:0]                                  perf_restore_cnt,
    output logic [31:0]                                  perf_ckpt_stall_cnt
`endif
);

    typedef struct packed {
        logic                      ready;
        logic [PHYS_REG_WIDTH-1:0] preg;
    } entry_t;

    typedef entry_t map_t [NUM_ARCH_REGS];

    localparam entry_t RESET_ENTRY = '{ready: 1'b1, preg: '0};

    map_t                       tbl;
    map_t                       tbl_snoop;
    map_t                       tbl_post;
    map_t                       tbl_next;
    map_t                       ckpt      [NUM_CKPT];
    map_t                       ckpt_snoop[NUM_CKPT];
    map_t                       ckpt_next [NUM_CKPT];
    logic [NUM_CKPT-1:0]        ckpt_busy;
    logic [NUM_CKPT-1:0]        busy_next;
    logic                       alloc_take;
    entry_t [RENAME_WIDTH-1:0]  rd1;
    entry_t [RENAME_WIDTH-1:0]  rd2;

    // Lowest free slot; 0 when every slot is busy (the alloc is then ignored).
    always_comb begin
        ckpt_id = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            if (!ckpt_busy[k]) ckpt_id = CKPT_W'(k);
        end
    end

    assign alloc_take = ckpt_alloc && !ckpt_full;

    // Source lookup. Written lowest-priority first so that later assignments
    // win: table, then CDB wakeup, then older-lane bypass, then x0.
    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            for (int s = 0; s < 2; s++) begin
                logic [ARCH_W-1:0] src;
                entry_t            e;
                src = (s == 0) ? ars1[j] : ars2[j];
                e   = tbl[src];
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (cdb_valid[c] && cdb_ard[c] == src && cdb_prd[c] == tbl[src].preg)
                        e.ready = 1'b1;
                end
                // Only strictly older lanes; the highest matching one wins.
                for (int i = 0; i < j; i++) begin
                    if (ren_valid[i] && rd_wen[i] && ard[i] == src)
                        e = '{ready: 1'b0, preg: prd[i]};
                end
                if (src == '0) e = RESET_ENTRY;
                if (s == 0) rd1[j] = e;
                else        rd2[j] = e;
            end
        end
    end

    // Next-state computation for the table, checkpoints and slot bookkeeping.
    // NOTE: blocking assignments here build up the post-group state step by
    // step within one evaluation; only the always_ff blocks use <=.
    always_comb begin
        tbl_snoop = tbl;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && tbl[cdb_ard[c]].preg == cdb_prd[c])
                tbl_snoop[cdb_ard[c]].ready = 1'b1;
        end

        // Snooping free slots is harmless: their contents are overwritten
        // on allocation.
        for (int k = 0; k < NUM_CKPT; k++) begin
            ckpt_snoop[k] = ckpt[k];
            for (int c = 0; c < NUM_CDB; c++) begin
                if (cdb_valid[c] && ckpt[k][cdb_ard[c]].preg == cdb_prd[c])
                    ckpt_snoop[k][cdb_ard[c]].ready = 1'b1;
            end
        end

        // Rename writes override CDB ready; ascending lane order lets the
        // highest lane win on a shared ard.
        tbl_post = tbl_snoop;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (ren_valid[i] && rd_wen[i] && ard[i] != '0)
                tbl_post[ard[i]] = '{ready: 1'b0, preg: prd[i]};
        end

        ckpt_next = ckpt_snoop;
        if (restore) begin
            tbl_next              = ckpt_snoop[restore_id];
            busy_next             = ckpt_busy & ~restore_kill_mask;
            busy_next[restore_id] = 1'b0;
        end else begin
            tbl_next  = tbl_post;
            busy_next = ckpt_busy;
            // The freed slot is still busy this cycle, so ckpt_id never
            // equals ckpt_free_id and a same-cycle alloc cannot reuse it.
            if (ckpt_free) busy_next[ckpt_free_id] = 1'b0;
            if (alloc_take) begin
                busy_next[ckpt_id] = 1'b1;
                ckpt_next[ckpt_id] = tbl_post;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl           <= '{default: RESET_ENTRY};
            ckpt_busy     <= '0;
            ckpt_full     <= 1'b0;
            prs1_rdata    <= {RENAME_WIDTH{RESET_ENTRY}};
            prs2_rdata    <= {RENAME_WIDTH{RESET_ENTRY}};
            ren_out_valid <= '0;
        end else begin
            tbl       <= tbl_next;
            ckpt_busy <= busy_next;
            ckpt_full <= &busy_next;
            if (restore) begin
                // Read data holds its previous value across a restore.
                ren_out_valid <= '0;
            end else begin
                prs1_rdata    <= rd1;
                prs2_rdata    <= rd2;
                ren_out_valid <= ren_valid;
            end
        end
    end

    // NOTE: checkpoint storage is deliberately not reset; ckpt_busy gates
    // every use, and a slot is fully written when it is allocated.
    always_ff @(posedge clk) begin
        ckpt <= ckpt_next;
    end

`ifdef RAT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_restore_cnt    <= '0;
            perf_ckpt_stall_cnt <= '0;
        end else begin
            if (restore)                 perf_restore_cnt    <= perf_restore_cnt + 32'd1;
            if (ckpt_alloc && ckpt_full) perf_ckpt_stall_cnt <= perf_ckpt_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rat_multi.sv
// -----------------------------------------------------------------------------
// tb_rat_multi -- directed self-checking bench for rat_multi.
// Inputs change 1 ns after the rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_rat_multi;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           ren_valid;
    logic [1:0][4:0]      ars1, ars2, ard;
    logic [1:0]           rd_wen;
    logic [1:0][5:0]      prd;
    logic [1:0][6:0]      prs1_rdata, prs2_rdata;
    logic [1:0]           ren_out_valid;
    logic                 ckpt_alloc;
    logic [1:0]           ckpt_id;
    logic                 ckpt_full;
    logic                 ckpt_free;
    logic [1:0]           ckpt_free_id;
    logic                 restore;
    logic [1:0]           restore_id;
    logic [3:0]           restore_kill_mask;
    logic [1:0]           cdb_valid;
    logic [1:0][4:0]      cdb_ard;
    logic [1:0][5:0]      cdb_prd;
`ifdef RAT_PERF_CNT_EN
    logic [31:0]          perf_restore_cnt, perf_ckpt_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rat_multi dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ars1(ars1), .ars2(ars2), .ard(ard),
        .rd_wen(rd_wen), .prd(prd),
        .prs1_rdata(prs1_rdata), .prs2_rdata(prs2_rdata),
        .ren_out_valid(ren_out_valid),
        .ckpt_alloc(ckpt_alloc), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free), .ckpt_free_id(ckpt_free_id),
        .restore(restore), .restore_id(restore_id),
        .restore_kill_mask(restore_kill_mask),
        .cdb_valid(cdb_valid), .cdb_ard(cdb_ard), .cdb_prd(cdb_prd)
`ifdef RAT_PERF_CNT_EN
        , .perf_restore_cnt(perf_restore_cnt),
        .perf_ckpt_stall_cnt(perf_ckpt_stall_cnt)
`endif
    );

    function automatic logic [6:0] mk(input logic r, input logic [5:0] p);
        return {r, p};
    endfunction

    task automatic idle();
        ren_valid = '0; ars1 = '0; ars2 = '0; ard = '0; rd_wen = '0; prd = '0;
        ckpt_alloc = 1'b0; ckpt_free = 1'b0; ckpt_free_id = '0;
        restore = 1'b0; restore_id = '0; restore_kill_mask = '0;
        cdb_valid = '0; cdb_ard = '0; cdb_prd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-lane rename write on lane 0, applied in the next cycle.
    task automatic write0(input logic [4:0] a, input logic [5:0] p);
        idle();
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = a; prd[0] = p;
        tick();
    endtask

    // Lane 0 reads ars1 = a; result is visible after the tick.
    task automatic read0(input logic [4:0] a);
        idle();
        ren_valid[0] = 1'b1; ars1[0] = a;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (ren_out_valid !== 2'b00) begin
            errors++; $display("FAIL reset_ren_out_valid got %b want 00", ren_out_valid);
        end
        checks++;
        if (prs1_rdata[1] !== mk(1, 0)) begin
            errors++; $display("FAIL reset_prs1 got %h want %h", prs1_rdata[1], mk(1, 0));
        end
        rst = 1'b0;
        ren_valid[0] = 1'b1; ars1[0] = 5'd5; ars2[0] = 5'd0;
        tick();
        checks++;
        if (prs1_rdata[0] !== mk(1, 0)) begin
            errors++; $display("FAIL reset_read_prs1 got %h want %h", prs1_rdata[0], mk(1, 0));
        end
        checks++;
        if (prs2_rdata[0] !== mk(1, 0)) begin
            errors++; $display("FAIL reset_read_prs2 got %h want %h", prs2_rdata[0], mk(1, 0));
        end
        checks++;
        if (ckpt_full !== 1'b0 || ckpt_id !== 2'd0) begin
            errors++; $display("FAIL reset_ckpt got full=%b id=%0d want full=0 id=0", ckpt_full, ckpt_id);
        end
        checks++;
        if (ren_out_valid !== 2'b01) begin
            errors++; $display("FAIL reset_ren_out_valid_follow got %b want 01", ren_out_valid);
        end
    endtask

    task automatic test_bypass();
        idle();
        ren_valid = 2'b11; rd_wen = 2'b11;
        ard[0] = 5'd3; prd[0] = 6'd17; ars1[0] = 5'd3;
        ard[1] = 5'd3; prd[1] = 6'd18; ars1[1] = 5'd3; ars2[1] = 5'd3;
        tick();
        checks++;
        if (prs1_rdata[1] !== mk(0, 17)) begin
            errors++; $display("FAIL bypass_lane1_prs1 got %h want %h", prs1_rdata[1], mk(0, 17));
        end
        checks++;
        if (prs2_rdata[1] !== mk(0, 17)) begin
            errors++; $display("FAIL bypass_lane1_prs2 got %h want %h", prs2_rdata[1], mk(0, 17));
        end
        checks++;
        if (prs1_rdata[0] !== mk(1, 0)) begin
            errors++; $display("FAIL bypass_no_self got %h want %h", prs1_rdata[0], mk(1, 0));
        end
        read0(5'd3);
        checks++;
        if (prs1_rdata[0] !== mk(0, 18)) begin
            errors++; $display("FAIL bypass_highest_lane_wins got %h want %h", prs1_rdata[0], mk(0, 18));
        end
    endtask

    task automatic test_cdb();
        write0(5'd4, 6'd9);
        idle();
        ren_valid[0] = 1'b1; ars1[0] = 5'd4;
        cdb_valid = 2'b10; cdb_ard[1] = 5'd4; cdb_prd[1] = 6'd9;
        tick();
        checks++;
        if (prs1_rdata[0] !== mk(1, 9)) begin
            errors++; $display("FAIL cdb_forward got %h want %h", prs1_rdata[0], mk(1, 9));
        end
        read0(5'd4);
        checks++;
        if (prs1_rdata[0] !== mk(1, 9)) begin
            errors++; $display("FAIL cdb_table_ready got %h want %h", prs1_rdata[0], mk(1, 9));
        end
        // Wrong preg on the CDB must not wake the entry.
        write0(5'd6, 6'd11);
        idle();
        ren_valid[0] = 1'b1; ars1[0] = 5'd6;
        cdb_valid = 2'b01; cdb_ard[0] = 5'd6; cdb_prd[0] = 6'd12;
        tick();
        checks++;
        if (prs1_rdata[0] !== mk(0, 11)) begin
            errors++; $display("FAIL cdb_preg_mismatch got %h want %h", prs1_rdata[0], mk(0, 11));
        end
        // Same-cycle rename overrides the CDB wakeup on that entry.
        idle();
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd6; prd[0] = 6'd13;
        cdb_valid = 2'b01; cdb_ard[0] = 5'd6; cdb_prd[0] = 6'd11;
        tick();
        read0(5'd6);
        checks++;
        if (prs1_rdata[0] !== mk(0, 13)) begin
            errors++; $display("FAIL rename_over_cdb got %h want %h", prs1_rdata[0], mk(0, 13));
        end
        // Writes to x0 are ignored, and x0 reads are never bypassed.
        idle();
        ren_valid = 2'b11; rd_wen[0] = 1'b1; ard[0] = 5'd0; prd[0] = 6'd5;
        ars1[1] = 5'd0;
        tick();
        checks++;
        if (prs1_rdata[1] !== mk(1, 0)) begin
            errors++; $display("FAIL x0_no_bypass got %h want %h", prs1_rdata[1], mk(1, 0));
        end
        read0(5'd0);
        checks++;
        if (prs1_rdata[0] !== mk(1, 0)) begin
            errors++; $display("FAIL x0_write_ignored got %h want %h", prs1_rdata[0], mk(1, 0));
        end
    endtask

    task automatic test_ckpt_restore();
        idle();
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd7; prd[0] = 6'd20;
        ckpt_alloc = 1'b1;
        #1;
        checks++;
        if (ckpt_id !== 2'd0) begin
            errors++; $display("FAIL ckpt_first_id got %0d want 0", ckpt_id);
        end
        tick();
        write0(5'd7, 6'd21);
        idle();
        ren_valid[0] = 1'b1; ars1[0] = 5'd7;
        cdb_valid = 2'b01; cdb_ard[0] = 5'd7; cdb_prd[0] = 6'd20;
        tick();
        checks++;
        if (prs1_rdata[0] !== mk(0, 21)) begin
            errors++; $display("FAIL ckpt_live_read got %h want %h", prs1_rdata[0], mk(0, 21));
        end
        // Restore with a rename and a read attempted in the same cycle.
        idle();
        restore = 1'b1; restore_id = 2'd0;
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd7; prd[0] = 6'd30; ars1[0] = 5'd9;
        tick();
        checks++;
        if (ren_out_valid !== 2'b00) begin
            errors++; $display("FAIL restore_ren_out_valid got %b want 00", ren_out_valid);
        end
        checks++;
        if (prs1_rdata[0] !== mk(0, 21)) begin
            errors++; $display("FAIL restore_rdata_hold got %h want %h", prs1_rdata[0], mk(0, 21));
        end
        checks++;
        if (ckpt_id !== 2'd0) begin
            errors++; $display("FAIL restore_slot_freed got %0d want 0", ckpt_id);
        end
        read0(5'd7);
        checks++;
        if (prs1_rdata[0] !== mk(1, 20)) begin
            errors++; $display("FAIL restore_snooped_map got %h want %h", prs1_rdata[0], mk(1, 20));
        end
    endtask

    task automatic test_full_kill();
        for (int k = 0; k < 4; k++) begin
            idle();
            ckpt_alloc = 1'b1;
            if (k > 0) begin
                ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd8; prd[0] = 6'(39 + k);
            end
            #1;
            checks++;
            if (ckpt_id !== 2'(k) || ckpt_full !== 1'b0) begin
                errors++; $display("FAIL alloc_id_%0d got id=%0d full=%b want id=%0d full=0", k, ckpt_id, ckpt_full, k);
            end
            tick();
        end
        checks++;
        if (ckpt_full !== 1'b1) begin
            errors++; $display("FAIL ckpt_full_set got %b want 1", ckpt_full);
        end
        idle();
        ckpt_alloc = 1'b1;
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd8; prd[0] = 6'd43;
        tick();
        checks++;
        if (ckpt_full !== 1'b1) begin
            errors++; $display("FAIL alloc_when_full got full=%b want 1", ckpt_full);
        end
`ifdef RAT_PERF_CNT_EN
        checks++;
        if (perf_ckpt_stall_cnt !== 32'd1) begin
            errors++; $display("FAIL perf_stall got %0d want 1", perf_ckpt_stall_cnt);
        end
`endif
        idle();
        restore = 1'b1; restore_id = 2'd1; restore_kill_mask = 4'b1100;
        tick();
        idle();
        #1;
        checks++;
        if (ckpt_full !== 1'b0 || ckpt_id !== 2'd1) begin
            errors++; $display("FAIL kill_mask got full=%b id=%0d want full=0 id=1", ckpt_full, ckpt_id);
        end
        read0(5'd8);
        checks++;
        if (prs1_rdata[0] !== mk(0, 40)) begin
            errors++; $display("FAIL restore_slot1_map got %h want %h", prs1_rdata[0], mk(0, 40));
        end
        // Alloc (gets slot 1) alongside a free of slot 0.
        idle();
        ckpt_alloc = 1'b1; ckpt_free = 1'b1; ckpt_free_id = 2'd0;
        tick();
        idle();
        // Freeing an already-free slot is a no-op.
        ckpt_free = 1'b1; ckpt_free_id = 2'd3;
        tick();
        idle();
        #1;
        checks++;
        if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
            errors++; $display("FAIL free_then_id got id=%0d full=%b want id=0 full=0", ckpt_id, ckpt_full);
        end
`ifdef RAT_PERF_CNT_EN
        checks++;
        if (perf_restore_cnt !== 32'd2) begin
            errors++; $display("FAIL perf_restore got %0d want 2", perf_restore_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid();
        idle();
        ckpt_alloc = 1'b1;
        ren_valid[0] = 1'b1; rd_wen[0] = 1'b1; ard[0] = 5'd8; prd[0] = 6'd50;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0 || ren_out_valid !== 2'b00) begin
            errors++; $display("FAIL rst_mid_ckpt got id=%0d full=%b rov=%b want 0 0 00", ckpt_id, ckpt_full, ren_out_valid);
        end
        ren_valid[1] = 1'b1; ars1[1] = 5'd8;
        tick();
        checks++;
        if (prs1_rdata[1] !== mk(1, 0)) begin
            errors++; $display("FAIL rst_mid_table got %h want %h", prs1_rdata[1], mk(1, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_cdb();
        test_ckpt_restore();
        test_full_kill();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rat_multi.md
Name: rat_multi

Overview:
Multi-lane register alias table for the rename stage. Each cycle it maps up to RENAME_WIDTH instructions' architectural sources to physical registers, with intra-group dependency bypass and CDB wakeup forwarding. It keeps NUM_CKPT internal branch checkpoints, and every checkpoint snoops the CDB so its ready bits stay current. A restore therefore reloads a fully up-to-date mapping in one cycle, with no external ROB copy.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; x0 hardwired.
ARCH_W, 5, log2(NUM_ARCH_REGS).
PHYS_REG_WIDTH, 6, physical register index width.
RENAME_WIDTH, 2, rename lanes per cycle (W).
NUM_CDB, 2, CDB broadcast ports (C).
NUM_CKPT, 4, checkpoint slots; CKPT_W = log2(NUM_CKPT).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ren_valid  in  W  lane i carries an instruction
ars1, ars2  in  W x ARCH_W  source arch regs per lane
ard  in  W x ARCH_W  dest arch reg per lane
rd_wen  in  W  lane i writes ard
prd  in  W x PHYS_REG_WIDTH  new phys dest from free list
prs1_rdata, prs2_rdata  out  W x (1+PHYS_REG_WIDTH)  {ready, preg}, registered
ren_out_valid  out  W  registered copy of ren_valid, 0 on restore
ckpt_alloc  in  1  snapshot post-group state this cycle
ckpt_id  out  CKPT_W  combinational; slot allocated if ckpt_alloc
ckpt_full  out  1  no free slot
ckpt_free  in  1  release slot ckpt_free_id (branch resolved correct)
ckpt_free_id  in  CKPT_W
restore  in  1  mispredict: reload from restore_id
restore_id  in  CKPT_W
restore_kill_mask  in  NUM_CKPT  younger slots to release on restore
cdb_valid  in  C
cdb_ard  in  C x ARCH_W
cdb_prd  in  C x PHYS_REG_WIDTH

Behaviour:
- Reset:
  - every table entry = {1, 0}; all checkpoint slots free.
  - prs*_rdata = {1, 0}; ren_out_valid = 0; ckpt_full = 0.
- Priority per cycle: rst > restore > normal.
- Normal cycle, CDB snoop:
  - For each c with cdb_valid, set ready on the table entry [cdb_ard] if its preg == cdb_prd.
  - Apply the same rule to every allocated checkpoint.
- Normal cycle, rename writes:
  - Lanes with ren_valid & rd_wen & ard != 0 write table[ard] = {0, prd].
  - Rename writes override the CDB ready update on the same entry.
  - When several lanes share an ard, the highest lane wins.
- Read, 1-cycle latency. Per lane j and source s, the first match wins:
  1. s == 0 -> {1, 0}.
  2. Highest lane i < j with valid, wen and ard_i == s -> {0, prd_i} (intra-group bypass).
  3. table[s].preg matches any valid cdb_prd (with cdb_ard == s) -> {1, preg}.
  4. Otherwise -> table[s].
  - A lane never bypasses from its own ard. Source reads see pre-group state plus earlier lanes only.
- Checkpoint allocate:
  - ckpt_id = lowest free slot.
  - When ckpt_alloc && !ckpt_full, the slot captures the table after this cycle's CDB and rename updates (the post-group state), then marks the slot allocated.
  - Alloc while ckpt_full is ignored; no state changes.
- ckpt_free: clears the allocated bit. Free of an unallocated slot is a no-op. A same-cycle alloc cannot reuse the slot until the next cycle.
- Restore cycle:
  - table = ckpt[restore_id] with this cycle's CDB ready updates applied.
  - Renames, ckpt_alloc and ckpt_free in that cycle are dropped.
  - Slot restore_id and every slot set in restore_kill_mask become free.
  - Next cycle: ren_out_valid = 0; prs*_rdata hold their previous values.
- ckpt_full = all slots allocated. It is registered state and updates the cycle after alloc/free/restore.
- Writes to x0 never change the table.

Optional Feature:
RAT_PERF_CNT_EN:
- Defined: adds outputs perf_restore_cnt[31:0] and perf_ckpt_stall_cnt[31:0], both reset to 0, wrapping at 2^32.
  - perf_restore_cnt increments each restore cycle.
  - perf_ckpt_stall_cnt increments each cycle ckpt_alloc && ckpt_full.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then read ars1=5 / ars2=0 on lane 0 -> next cycle prs1={1,0}, prs2={1,0}, ckpt_full=0.
- Intra-group bypass:
  - Stimulus: lane0 ard=3 prd=17; lane1 ars1=3 ars2=3 ard=3 prd=18.
  - Response: lane1 prs1=prs2={0,17}; the following cycle a read of 3 returns {0,18}.
- CDB forwarding:
  - Stimulus: table[4]={0,9}; same cycle cdb_valid[1]=1 with cdb_ard=4, cdb_prd=9, and lane0 reads ars1=4.
  - Response: prs1={1,9}; a subsequent read gives {1,9}.
- Checkpoint snoop and restore:
  - Stimulus: rename ard=7 prd=20 with ckpt_alloc (id 0). Rename ard=7 prd=21. CDB prd=20 ard=7. Restore id 0.
  - Response: read of 7 returns {1,20}; slot 0 free; ren_out_valid=0 the cycle after restore.
- Full and kill mask:
  - Stimulus: allocate 4 slots -> ckpt_full=1. 5th alloc ignored (perf_ckpt_stall_cnt=1 when enabled). Restore id 1 with kill_mask=4'b1100.
  - Response: slots 1-3 free, slot 0 allocated, ckpt_full=0, next ckpt_id=1.
- rst asserted mid-group with ckpt_alloc -> all slots free and table {1,0} next cycle.
